mix_bus_sequencer: RTL and testbench
====================================

// Module: mix_bus_sequencer
// PURPOSE
//  Frame-level scheduler for the mix datapath. On each frame_start it walks every (bus, channel) pair,
//  reads sample/gain from external memories, MACs into a wide accumulator per bus, and clamps the
//  result to 36 bits. The 36-bit value feeds the saturate stage (36->24, overflow flag). It emits one
//  24-bit result per bus and drives per-bus clip indicators. Sits between the channel memories and the output serializer.
// PARAMETERS
//  N_CHANNELS  8      input channels summed per bus (>=1)
//  N_BUSES     4      output buses per frame (>=1)
//  CLIP_HOLD   48000  frames a clip indication is held after the last overflow (MIX_CLIP_HOLD_EN only)
// PORTS
//  clk             in   1    system clock
//  reset           in   1    asynchronous, active-high reset
//  frame_start     in   1    one-cycle pulse: start a new frame
//  rd_en           out  1    memory read strobe
//  rd_bus          out  BW   bus index, BW=$clog2(N_BUSES) (min 1)
//  rd_chan         out  CW   channel index, CW=$clog2(N_CHANNELS) (min 1)
//  sample_in       in   24   signed Q1.23, valid 1 cycle after rd_en
//  gain_in         in   12   signed Q6.6 (0x040=1.0), valid 1 cycle after rd_en
//  out_sample      out  24   saturated bus result
//  out_bus         out  BW   bus index of out_sample
//  out_valid       out  1    one-cycle pulse per bus result
//  clip            out  N_BUSES  per-bus clip indicator
//  busy            out  1    frame in progress
//  frame_overrun   out  1    one-cycle pulse: frame_start dropped
// BEHAVIOUR
//  - Reset is asynchronous. All outputs, pipeline registers, the accumulator and the hold counters go to 0. FSM goes to IDLE.
//    Reset mid-frame aborts the frame. No out_valid is produced for the aborted frame.
//  - FSM states: IDLE, ISSUE, DRAIN.
//    IDLE->ISSUE on frame_start; busy=1 from the next cycle.
//    ISSUE drives rd_en=1 for N_BUSES*N_CHANNELS consecutive cycles, with rd_chan incrementing fastest.
//    The order is (0,0),(0,1)..(N_BUSES-1,N_CHANNELS-1).
//    ISSUE->DRAIN after the last address. DRAIN->IDLE in the cycle the last out_valid is high; busy=0 next cycle.
//  - frame_start is accepted only when busy=0. If it arrives while busy=1, frame_overrun pulses the next cycle and the request is dropped.
//  - Pipeline, with cycle k = address cycle:
//    k+1: product register <= sample_in*gain_in (36b signed).
//    k+2: acc (40b) <= product if first channel of the bus, else acc+product.
//    k+3: clamp acc to 36b, saturate 36->24, register the result.
//    k+4: out_sample/out_bus/out_valid.
//    first/last/bus tags travel with the data.
//  - Clamp: if acc[39:35] is not all equal, substitute {acc[39],{35{~acc[39]}}}.
//  - Saturate: result = in[29:6] when in[35:29] is all equal. Otherwise output 0x7FFFFF (in[35]=0) or 0x800000 (in[35]=1), and flag overflow.
//    overflow is also set when the clamp fired.
//  - Result for bus b: out_valid high exactly once, 4 cycles after the (b,N_CHANNELS-1) address cycle.
//    Results for a frame appear on consecutive N_CHANNELS-spaced pulses.
//  - out_sample and out_bus hold their value between pulses.
//  - clip[b] updates only in the cycle its out_valid rises.
// CONFIGURATION
//  MIX_CLIP_HOLD_EN defined: each bus has a hold counter cnt.
//    On overflow: clip=1, cnt=CLIP_HOLD.
//    Otherwise: clip=(cnt!=0), and cnt decrements if nonzero.
//    CLIP_HOLD=0 gives per-frame behaviour.
//  MIX_CLIP_HOLD_EN undefined: clip[b]=overflow of bus b's latest result. No counters; CLIP_HOLD is ignored.
// TESTING
//  1 Reset: assert reset -> all outputs 0, rd_en 0, busy 0. Deassert, no frame_start -> remains idle.
//  2 All samples 0x0FFFFF, gains 0x040, one frame -> 4 pulses, each out_sample=0x7FFFF8, clip=0.
//    Samples 0x100000 -> out_sample=0x7FFFFF, clip=all 1.
//  3 Samples 0xF00000, gains 0x040 -> out_sample=0x800000 exactly, clip=0 (negative boundary, no overflow).
//  4 Samples 0x800000, gains 0x800 (-32.0) -> acc=2^37, clamp fires -> out_sample=0x7FFFFF, clip=1.
//  5 frame_start again 5 cycles after acceptance -> frame_overrun pulse, still exactly 4 out_valid.
//    Reset 10 cycles into a frame -> no out_valid. Next frame gives 4 correct results.
//  6 MIX_CLIP_HOLD_EN, CLIP_HOLD=3: overflow frame, then clean frames -> clip=1 for the overflow frame plus 3 clean frames, 0 on the 4th.
//    Without the macro -> clip=0 on the 1st clean frame.

Source files
------------

// File: rtl/mix_bus_sequencer_if.sv
// Signal bundle between the mix sequencer, the channel/gain memories and the output serializer.
// slave = sequencer side, master = memory/serializer side.
interface mix_bus_sequencer_if #(
    parameter int N_CHANNELS = 8,
    parameter int N_BUSES    = 4
);
    localparam int BW = (N_BUSES > 1) ? $clog2(N_BUSES) : 1;
    localparam int CW = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;

    logic               frame_start;
    logic               rd_en;
    logic [BW-1:0]      rd_bus;
    logic [CW-1:0]      rd_chan;
    logic [23:0]        sample_in;
    logic [11:0]        gain_in;
    logic [23:0]        out_sample;
    logic [BW-1:0]      out_bus;
    logic               out_valid;
    logic [N_BUSES-1:0] clip;
    logic               busy;
    logic               frame_overrun;

    modport slave (
        input  frame_start, sample_in, gain_in,
        output rd_en, rd_bus, rd_chan, out_sample, out_bus, out_valid,
               clip, busy, frame_overrun
    );

    modport master (
        output frame_start, sample_in, gain_in,
        input  rd_en, rd_bus, rd_chan, out_sample, out_bus, out_valid,
               clip, busy, frame_overrun
    );
endinterface

// File: rtl/mix_bus_sequencer.sv
// Frame scheduler: walks every (bus, channel), MACs sample*gain per bus, clamps/saturates to 24 bits.
// Define MIX_CLIP_HOLD_EN to hold each clip indicator for CLIP_HOLD frames after the last overflow.
//
// state | meaning
// IDLE  | waiting for frame_start
// ISSUE | one memory read per cycle, channel index fastest
// DRAIN | pipeline emptying until the last bus result is out
module mix_bus_sequencer #(
    parameter int N_CHANNELS = 8,
    parameter int N_BUSES    = 4,
    parameter int CLIP_HOLD  = 48000
) (
    input logic                clk,
    input logic                reset,
    mix_bus_sequencer_if.slave mix
);
    localparam int BW = (N_BUSES > 1) ? $clog2(N_BUSES) : 1;
    localparam int CW = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, next_state;

    logic [BW-1:0] bus_cnt;
    logic [CW-1:0] chan_cnt;
    logic          last_chan, last_addr, last_result;
    logic          rd_en, busy;

    // Tags travelling with the data: valid, first channel, last channel, bus index.
    logic          v1, f1, l1, v2, f2, l2, v3, l3;
    logic [BW-1:0] b1, b2, b3;

    logic signed [35:0] sx, gx, prod;
    logic signed [39:0] acc;
    logic        [35:0] clamped;
    logic               clamp_fire, sat_ovf, ovf;
    logic        [23:0] sat_val;
    logic               unused_low_bits;

    logic [23:0]        out_sample_q;
    logic [BW-1:0]      out_bus_q;
    logic               out_valid_q;
    logic [N_BUSES-1:0] clip_q;
    logic               frame_overrun_q;

    assign last_chan   = (chan_cnt == CW'(N_CHANNELS - 1));
    assign last_addr   = last_chan && (bus_cnt == BW'(N_BUSES - 1));
    assign last_result = out_valid_q && (out_bus_q == BW'(N_BUSES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        rd_en      = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (mix.frame_start) next_state = ISSUE;
            end
            ISSUE: begin
                rd_en = 1'b1;
                if (last_addr) next_state = DRAIN;
            end
            DRAIN: begin
                if (last_result) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_cnt  <= '0;
            chan_cnt <= '0;
        end else if (state != ISSUE) begin
            bus_cnt  <= '0;
            chan_cnt <= '0;
        end else if (last_chan) begin
            chan_cnt <= '0;
            bus_cnt  <= bus_cnt + BW'(1);
        end else begin
            chan_cnt <= chan_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) frame_overrun_q <= 1'b0;
        else       frame_overrun_q <= mix.frame_start && busy;
    end

    assign sx = 36'($signed(mix.sample_in));
    assign gx = 36'($signed(mix.gain_in));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {v1, f1, l1, v2, f2, l2, v3, l3} <= '0;
            b1   <= '0;
            b2   <= '0;
            b3   <= '0;
            prod <= '0;
            acc  <= '0;
        end else begin
            v1 <= rd_en;
            f1 <= rd_en && (chan_cnt == '0);
            l1 <= rd_en && last_chan;
            b1 <= bus_cnt;
            prod <= sx * gx;
            v2 <= v1;
            f2 <= f1;
            l2 <= l1;
            b2 <= b1;
            if (v2) acc <= f2 ? 40'(prod) : acc + 40'(prod);
            v3 <= v2;
            l3 <= l2;
            b3 <= b2;
        end
    end

    always_comb begin
        clamp_fire = !((&acc[39:35]) || !(|acc[39:35]));
        clamped    = clamp_fire ? {acc[39], {35{~acc[39]}}} : acc[35:0];
        sat_ovf    = !((&clamped[35:29]) || !(|clamped[35:29]));
        if (!sat_ovf)        sat_val = clamped[29:6];
        else if (clamped[35]) sat_val = 24'h800000;
        else                 sat_val = 24'h7FFFFF;
        ovf = sat_ovf || clamp_fire;
    end

    assign unused_low_bits = ^clamped[5:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_sample_q <= '0;
            out_bus_q    <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            out_valid_q <= v3 && l3;
            if (v3 && l3) begin
                out_sample_q <= sat_val;
                out_bus_q    <= b3;
            end
        end
    end

`ifdef MIX_CLIP_HOLD_EN
    localparam int HW = (CLIP_HOLD > 0) ? $clog2(CLIP_HOLD + 1) : 1;
    logic [HW-1:0] hold_cnt [N_BUSES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clip_q <= '0;
            for (int i = 0; i < N_BUSES; i++) hold_cnt[i] <= '0;
        end else if (v3 && l3) begin
            if (ovf) begin
                clip_q[b3]   <= 1'b1;
                hold_cnt[b3] <= HW'(CLIP_HOLD);
            end else begin
                clip_q[b3] <= (hold_cnt[b3] != '0);
                if (hold_cnt[b3] != '0) hold_cnt[b3] <= hold_cnt[b3] - HW'(1);
            end
        end
    end
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          clip_q     <= '0;
        else if (v3 && l3)  clip_q[b3] <= ovf;
    end
`endif

    assign mix.rd_en         = rd_en;
    assign mix.rd_bus        = bus_cnt;
    assign mix.rd_chan       = chan_cnt;
    assign mix.busy          = busy;
    assign mix.out_sample    = out_sample_q;
    assign mix.out_bus       = out_bus_q;
    assign mix.out_valid     = out_valid_q;
    assign mix.clip          = clip_q;
    assign mix.frame_overrun = frame_overrun_q;
endmodule

// File: tb/tb_mix_bus_sequencer.sv
// Bench for mix_bus_sequencer: table-driven memory model, frame-level arithmetic reference and a
// per-cycle compare process. Honours MIX_CLIP_HOLD_EN in its clip model.
module tb_mix_bus_sequencer;
    localparam int NC = 8;
    localparam int NB = 4;
    localparam int BW = 2;
    localparam int CW = 3;
    localparam int CLIP_HOLD = 3;

    logic clk = 1'b0;
    logic reset;

    mix_bus_sequencer_if #(.N_CHANNELS(NC), .N_BUSES(NB)) mix_if ();

    mix_bus_sequencer #(.N_CHANNELS(NC), .N_BUSES(NB), .CLIP_HOLD(CLIP_HOLD)) dut (
        .clk   (clk),
        .reset (reset),
        .mix   (mix_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          b;
        logic [23:0] val;
        logic        ovf;
    } ev_t;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int t0 = -1000;
    int busy_end = -1;
    int dut_pulses = 0;
    int dut_ovr = 0;

    logic [23:0] samp_tab [NB][NC];
    logic [11:0] gain_tab [NB][NC];

    ev_t evq[$];
    int  ovr_q[$];

    logic [23:0]   exp_sample = '0;
    logic [BW-1:0] exp_bus = '0;
    logic [NB-1:0] mclip = '0;
    int            mhold [NB];

    logic          cap_en = 1'b0;
    logic [BW-1:0] cap_b = '0;
    logic [CW-1:0] cap_c = '0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: exact sum over channels, then saturate to the 24-bit Q1.23 range.
    function automatic void model_bus(input int b, output logic [23:0] val, output logic ovf);
        longint s = 0;
        longint lim = longint'(1) <<< 29;
        for (int c = 0; c < NC; c++)
            s += longint'($signed(samp_tab[b][c])) * longint'($signed(gain_tab[b][c]));
        if (s > lim - 1) begin
            val = 24'h7FFFFF;
            ovf = 1'b1;
        end else if (s < -lim) begin
            val = 24'h800000;
            ovf = 1'b1;
        end else begin
            val = 24'(s >>> 6);
            ovf = 1'b0;
        end
    endfunction

    // Memory: address seen in cycle k answers during cycle k+1; garbage otherwise.
    always @(negedge clk) begin
        cap_en = mix_if.rd_en;
        cap_b  = mix_if.rd_bus;
        cap_c  = mix_if.rd_chan;
    end

    always @(posedge clk) begin
        #1;
        if (cap_en) begin
            mix_if.sample_in = samp_tab[cap_b][cap_c];
            mix_if.gain_in   = gain_tab[cap_b][cap_c];
        end else begin
            mix_if.sample_in = 24'($urandom);
            mix_if.gain_in   = 12'($urandom);
        end
    end

    always @(negedge clk) begin
        int   a;
        logic exp_ovr, exp_v;
        ev_t  ev;
        if (reset) begin
            chk("rst_rd_en", mix_if.rd_en, 0);
            chk("rst_busy", mix_if.busy, 0);
            chk("rst_out_valid", mix_if.out_valid, 0);
            chk("rst_out_sample", mix_if.out_sample, 0);
            chk("rst_out_bus", mix_if.out_bus, 0);
            chk("rst_clip", mix_if.clip, 0);
            chk("rst_overrun", mix_if.frame_overrun, 0);
        end else begin
            a = cyc - t0 - 1;
            chk("rd_en", mix_if.rd_en, (a >= 0 && a < NB * NC) ? 1 : 0);
            if (a >= 0 && a < NB * NC) begin
                chk("rd_bus", mix_if.rd_bus, a / NC);
                chk("rd_chan", mix_if.rd_chan, a % NC);
            end
            chk("busy", mix_if.busy, (cyc >= t0 + 1 && cyc <= busy_end) ? 1 : 0);
            exp_ovr = (ovr_q.size() > 0 && ovr_q[0] == cyc);
            if (exp_ovr) void'(ovr_q.pop_front());
            chk("frame_overrun", mix_if.frame_overrun, exp_ovr);
            exp_v = (evq.size() > 0 && evq[0].cyc == cyc);
            if (exp_v) begin
                ev = evq.pop_front();
                exp_sample = ev.val;
                exp_bus    = BW'(ev.b);
`ifdef MIX_CLIP_HOLD_EN
                if (ev.ovf) begin
                    mclip[ev.b] = 1'b1;
                    mhold[ev.b] = CLIP_HOLD;
                end else begin
                    mclip[ev.b] = (mhold[ev.b] != 0);
                    if (mhold[ev.b] > 0) mhold[ev.b]--;
                end
`else
                mclip[ev.b] = ev.ovf;
`endif
            end
            chk("out_valid", mix_if.out_valid, exp_v);
            chk("out_sample", mix_if.out_sample, exp_sample);
            chk("out_bus", mix_if.out_bus, exp_bus);
            chk("clip", mix_if.clip, mclip);
            if (mix_if.out_valid) dut_pulses++;
            if (mix_if.frame_overrun) dut_ovr++;
        end
    end

    task automatic req_frame();
        ev_t         ev;
        logic [23:0] v;
        logic        o;
        mix_if.frame_start = 1'b1;
        if (cyc >= t0 + 1 && cyc <= busy_end) begin
            ovr_q.push_back(cyc + 1);
        end else begin
            t0 = cyc;
            busy_end = cyc + NB * NC + 4;
            for (int b = 0; b < NB; b++) begin
                model_bus(b, v, o);
                ev.cyc = cyc + NC * (b + 1) + 4;
                ev.b   = b;
                ev.val = v;
                ev.ovf = o;
                evq.push_back(ev);
            end
        end
        @(posedge clk); #1;
        mix_if.frame_start = 1'b0;
    endtask

    task automatic wait_done();
        int guard = 0;
        while (cyc <= busy_end && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("frame_timeout", (guard < 200) ? 1 : 0, 1);
    endtask

    task automatic run_frame();
        int p0 = dut_pulses;
        req_frame();
        wait_done();
        chk("pulses_per_frame", dut_pulses - p0, NB);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        mix_if.frame_start = 1'b0;
        evq.delete();
        ovr_q.delete();
        t0 = -1000;
        busy_end = -1;
        mclip = '0;
        exp_sample = '0;
        exp_bus = '0;
        for (int b = 0; b < NB; b++) mhold[b] = 0;
        repeat (n) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic fill(input logic [23:0] s, input logic [11:0] g);
        for (int b = 0; b < NB; b++)
            for (int c = 0; c < NC; c++) begin
                samp_tab[b][c] = s;
                gain_tab[b][c] = g;
            end
    endtask

    task automatic fill_rand();
        int mode, r;
        for (int b = 0; b < NB; b++) begin
            mode = int'($urandom_range(0, 2));
            for (int c = 0; c < NC; c++) begin
                case (mode)
                    0: begin
                        samp_tab[b][c] = 24'($urandom);
                        gain_tab[b][c] = 12'($urandom);
                    end
                    1: begin
                        r = int'($urandom_range(0, 2097152)) - 1048576;
                        samp_tab[b][c] = 24'(r);
                        r = int'($urandom_range(0, 2048)) - 1024;
                        gain_tab[b][c] = 12'(r);
                    end
                    default: begin
                        r = int'($urandom_range(0, 1048576)) - 524288;
                        samp_tab[b][c] = 24'(r);
                        r = int'($urandom_range(0, 128)) - 64;
                        gain_tab[b][c] = 12'(r);
                    end
                endcase
            end
        end
    endtask

    initial begin
        int p0, o0;
        logic [NB-1:0] exp_clip;
        reset = 1'b1;
        mix_if.frame_start = 1'b0;
        mix_if.sample_in = '0;
        mix_if.gain_in = '0;
        for (int b = 0; b < NB; b++) mhold[b] = 0;
        fill(24'h0, 12'h0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        fill(24'h0FFFFF, 12'h040);
        run_frame();
        chk("pos_in_range_sample", mix_if.out_sample, 24'h7FFFF8);
        chk("pos_in_range_clip", mix_if.clip, 4'h0);

        fill(24'h100000, 12'h040);
        run_frame();
        chk("pos_overflow_sample", mix_if.out_sample, 24'h7FFFFF);
        chk("pos_overflow_clip", mix_if.clip, 4'hF);

        do_reset(2);
        fill(24'hF00000, 12'h040);
        run_frame();
        chk("neg_boundary_sample", mix_if.out_sample, 24'h800000);
        chk("neg_boundary_clip", mix_if.clip, 4'h0);

        fill(24'h800000, 12'h800);
        run_frame();
        chk("clamp_sample", mix_if.out_sample, 24'h7FFFFF);
        chk("clamp_clip", mix_if.clip, 4'hF);

        fill(24'h0FFFFF, 12'h040);
        for (int i = 1; i <= 4; i++) begin
            run_frame();
`ifdef MIX_CLIP_HOLD_EN
            exp_clip = (i <= CLIP_HOLD) ? 4'hF : 4'h0;
`else
            exp_clip = 4'h0;
`endif
            chk("clip_after_overflow", mix_if.clip, exp_clip);
        end

        p0 = dut_pulses;
        o0 = dut_ovr;
        req_frame();
        repeat (4) @(posedge clk);
        #1;
        req_frame();
        wait_done();
        chk("overrun_pulses", dut_ovr - o0, 1);
        chk("overrun_frame_results", dut_pulses - p0, NB);

        p0 = dut_pulses;
        req_frame();
        repeat (9) @(posedge clk);
        #1;
        do_reset(1);
        repeat (50) @(posedge clk);
        #1;
        chk("aborted_frame_results", dut_pulses - p0, 0);
        fill_rand();
        run_frame();

        for (int f = 0; f < 30; f++) begin
            fill_rand();
            req_frame();
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 30)) @(posedge clk);
                #1;
                req_frame();
            end
            wait_done();
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
